// File: rtl/sender_tree_sched.sv
// sender_tree_sched: batch sequencer for the sender tree cluster.
// Each batch launches the cluster with seed_lat + batch, waits for the
// aggregate done (bounded by a timeout), then drains the TREE_NUM tree
// outputs in index order onto a valid/ready stream.
module sender_tree_sched #(
  parameter int TREE_NUM       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         func_in,
  input  logic [127:0] seed_in,
  input  logic [127:0] delta_in,
  input  logic [15:0]  num_batches,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         tree_enable,
  output logic         tree_func,
  output logic [127:0] tree_seed,
  output logic [127:0] tree_delta,
  output logic [31:0]  tree_msg_index,
  input  logic         tree_done,
  input  logic [127:0] tree_out,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int IDX_W = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TREE_NUM - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_SEL     = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [127:0]     r_seed;
  logic [15:0]      r_nb;
  logic [15:0]      r_batch;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_timer;

  logic         r_busy;
  logic         r_done;
  logic         r_error;
  logic         r_tree_enable;
  logic         r_tree_func;
  logic [127:0] r_tree_seed;
  logic [127:0] r_tree_delta;
  logic [31:0]  r_msg_index;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_out_last;

  logic             w_idx_last;
  logic             w_batch_last;
  logic             w_hs;
  logic [15:0]      w_batch_inc;
  logic [IDX_W-1:0] w_idx_inc;

  assign w_idx_last   = (r_idx == IDX_LAST);
  assign w_batch_last = (r_batch == (r_nb - 16'd1));
  assign w_hs         = r_out_valid & out_ready;
  assign w_batch_inc  = r_batch + 16'd1;
  assign w_idx_inc    = r_idx + IDX_W'(1);

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign tree_enable    = r_tree_enable;
  assign tree_func      = r_tree_func;
  assign tree_seed      = r_tree_seed;
  assign tree_delta     = r_tree_delta;
  assign tree_msg_index = r_msg_index;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;

  // Next-state selection for the batch sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start && (num_batches != 16'd0)) w_state_next = S_LAUNCH;
      S_LAUNCH:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (tree_done)              w_state_next = S_SEL;
        else if (r_timer == TMR_LAST) w_state_next = S_ERR;
      end
      S_SEL:     w_state_next = S_PRESENT;
      S_PRESENT: if (w_hs) w_state_next = w_idx_last ? S_NEXT : S_SEL;
      S_NEXT:    w_state_next = w_batch_last ? S_FINISH : S_LAUNCH;
      S_FINISH:  w_state_next = S_IDLE;
      S_ERR:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Registered outputs and datapath, updated on the transition into each state
  // so that every output is valid for the whole cycle of the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed        <= '0;
      r_nb          <= '0;
      r_batch       <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_tree_enable <= 1'b0;
      r_tree_func   <= 1'b0;
      r_tree_seed   <= '0;
      r_tree_delta  <= '0;
      r_msg_index   <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
    end else begin
      r_busy        <= (w_state_next != S_IDLE);
      r_done        <= 1'b0;
      r_tree_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            if (num_batches != 16'd0) begin
              r_seed        <= seed_in;
              r_nb          <= num_batches;
              r_batch       <= '0;
              r_tree_func   <= func_in;
              r_tree_delta  <= delta_in;
              r_tree_seed   <= seed_in;
              r_tree_enable <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT: begin
          if (tree_done) begin
            r_idx       <= '0;
            r_msg_index <= '0;
          end else if (r_timer == TMR_LAST) begin
            r_error     <= 1'b1;
            r_out_valid <= 1'b0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_SEL: begin
          // tree_msg_index has been stable for a full cycle, so tree_out is settled.
          r_out_valid <= 1'b1;
          r_out_data  <= tree_out;
          r_out_last  <= w_idx_last && w_batch_last;
        end
        S_PRESENT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!w_idx_last) begin
              r_idx       <= w_idx_inc;
              r_msg_index <= {{(32-IDX_W){1'b0}}, w_idx_inc};
            end
          end
        end
        S_NEXT: begin
          if (w_batch_last) begin
            r_done <= 1'b1;
          end else begin
            r_batch       <= w_batch_inc;
            r_tree_seed   <= r_seed + {112'd0, w_batch_inc};
            r_tree_enable <= 1'b1;
          end
        end
        S_ERR: r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sender_tree_sched.sv
// Directed bench for sender_tree_sched: single batch, backpressure, seed wrap,
// zero batches / ignored start, timeout (second instance) and reset mid-drain.
module tb_sender_tree_sched;

  localparam int TREE_NUM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic         func_in = 1'b0;
  logic [127:0] seed_in = '0;
  logic [127:0] delta_in = '0;
  logic [15:0]  num_batches = '0;
  logic         out_ready = 1'b1;

  logic         busy, done, error, tree_enable, tree_func;
  logic [127:0] tree_seed, tree_delta;
  logic [31:0]  tree_msg_index;
  logic         tree_done;
  logic [127:0] tree_out;
  logic         out_valid, out_last;
  logic [127:0] out_data;

  logic         busy2, done2, error2, tree_enable2, tree_func2;
  logic [127:0] tree_seed2, tree_delta2, out_data2;
  logic [31:0]  tree_msg_index2;
  logic         out_valid2, out_last2;
  logic         tree_done2 = 1'b0;
  logic [127:0] tree_out2 = '0;
  logic         out_ready2 = 1'b1;

  sender_tree_sched #(.TREE_NUM(TREE_NUM), .TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .func_in(func_in), .seed_in(seed_in),
    .delta_in(delta_in), .num_batches(num_batches), .busy(busy), .done(done),
    .error(error), .tree_enable(tree_enable), .tree_func(tree_func),
    .tree_seed(tree_seed), .tree_delta(tree_delta), .tree_msg_index(tree_msg_index),
    .tree_done(tree_done), .tree_out(tree_out), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  sender_tree_sched #(.TREE_NUM(TREE_NUM), .TIMEOUT_CYCLES(16)) u_dut_to (
    .clk(clk), .rst(rst), .start(start2), .func_in(func_in), .seed_in(seed_in),
    .delta_in(delta_in), .num_batches(num_batches), .busy(busy2), .done(done2),
    .error(error2), .tree_enable(tree_enable2), .tree_func(tree_func2),
    .tree_seed(tree_seed2), .tree_delta(tree_delta2), .tree_msg_index(tree_msg_index2),
    .tree_done(tree_done2), .tree_out(tree_out2), .out_valid(out_valid2),
    .out_data(out_data2), .out_last(out_last2), .out_ready(out_ready2)
  );

  // Cluster model: selected output is 0xA0 + index; done rises 20 cycles after enable.
  assign tree_out = 128'hA0 + {96'd0, tree_msg_index};
  int cl_cnt;
  always @(posedge clk) begin
    if (rst) begin
      cl_cnt    <= 0;
      tree_done <= 1'b0;
    end else if (tree_enable) begin
      cl_cnt    <= 20;
      tree_done <= 1'b0;
    end else if (cl_cnt != 0) begin
      cl_cnt <= cl_cnt - 1;
      if (cl_cnt == 1) tree_done <= 1'b1;
    end
  end

  // Monitor: record accepted words, launches and done pulses.
  logic [127:0] word_data [0:255];
  logic         word_last [0:255];
  logic [127:0] en_seed   [0:63];
  int word_cnt = 0, en_cnt = 0, done_cnt = 0, done2_cnt = 0;
  int cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (out_valid && out_ready && word_cnt < 256) begin
        word_data[word_cnt] <= out_data;
        word_last[word_cnt] <= out_last;
        word_cnt            <= word_cnt + 1;
        last_hs_cyc         <= cyc;
        $display("[TB] word %0d data=%0h last=%0b", word_cnt, out_data, out_last);
      end
      if (tree_enable && en_cnt < 64) begin
        en_seed[en_cnt] <= tree_seed;
        en_cnt          <= en_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (done2) done2_cnt <= done2_cnt + 1;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic f, input logic [127:0] s, input logic [127:0] d,
                           input logic [15:0] nb);
    func_in = f; seed_in = s; delta_in = d; num_batches = nb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(done), 128'd1);
    @(negedge clk);
  endtask

  task automatic wait_word(input logic [127:0] w, input int max_cyc);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_data === w) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int wb, eb, db, n, lastc;
    logic [127:0] s;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",   128'(busy), 128'd0);
    check("rst_done",   128'(done), 128'd0);
    check("rst_error",  128'(error), 128'd0);
    check("rst_enable", 128'(tree_enable), 128'd0);
    check("rst_valid",  128'(out_valid), 128'd0);
    check("rst_data",   out_data, 128'd0);
    check("rst_seed",   tree_seed, 128'd0);
    check("rst_index",  128'(tree_msg_index), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single batch
    wb = word_cnt; eb = en_cnt; db = done_cnt;
    start_job(1'b1, 128'h10, 128'h55, 16'd1);
    check("t1_enable", 128'(tree_enable), 128'd1);
    check("t1_seed",   tree_seed, 128'h10);
    check("t1_busy",   128'(busy), 128'd1);
    check("t1_func",   128'(tree_func), 128'd1);
    check("t1_delta",  tree_delta, 128'h55);
    @(negedge clk);
    check("t1_enable_pulse", 128'(tree_enable), 128'd0);
    wait_done("t1_done", 200);
    check("t1_nwords", 128'(word_cnt - wb), 128'd8);
    for (int i = 0; i < 8; i++) begin
      check("t1_word", word_data[wb+i], 128'hA0 + 128'(i));
      check("t1_last", 128'(word_last[wb+i]), (i == 7) ? 128'd1 : 128'd0);
    end
    check("t1_nenable", 128'(en_cnt - eb), 128'd1);
    check("t1_ndone",   128'(done_cnt - db), 128'd1);
    check("t1_done_lat", 128'((done_cyc - last_hs_cyc) >= 1 && (done_cyc - last_hs_cyc) <= 3), 128'd1);
    check("t1_idle", 128'(busy), 128'd0);

    // Backpressure on word 3
    wb = word_cnt;
    start_job(1'b0, 128'h10, 128'h0, 16'd1);
    wait_word(128'hA3, 300);
    check("t2_reach_w3", out_data, 128'hA3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_hold_valid", 128'(out_valid), 128'd1);
      check("t2_hold_data",  out_data, 128'hA3);
      check("t2_hold_last",  128'(out_last), 128'd0);
    end
    out_ready = 1'b1;
    wait_done("t2_done", 200);
    check("t2_nwords", 128'(word_cnt - wb), 128'd8);
    for (int i = 0; i < 8; i++) check("t2_word", word_data[wb+i], 128'hA0 + 128'(i));

    // Multi-batch with seed wrap
    wb = word_cnt; eb = en_cnt; db = done_cnt;
    s = ~128'd1;
    start_job(1'b0, s, 128'h3, 16'd3);
    wait_done("t3_done", 1000);
    check("t3_nenable", 128'(en_cnt - eb), 128'd3);
    check("t3_seed0", en_seed[eb],   ~128'd1);
    check("t3_seed1", en_seed[eb+1], ~128'd0);
    check("t3_seed2", en_seed[eb+2], 128'd0);
    check("t3_nwords", 128'(word_cnt - wb), 128'd24);
    lastc = 0;
    for (int i = 0; i < 24; i++) begin
      check("t3_word", word_data[wb+i], 128'hA0 + 128'(i % 8));
      if (word_last[wb+i]) lastc++;
    end
    check("t3_nlast", 128'(lastc), 128'd1);
    check("t3_last_pos", 128'(word_last[wb+23]), 128'd1);
    check("t3_ndone", 128'(done_cnt - db), 128'd1);

    // Zero batches
    wb = word_cnt; eb = en_cnt; db = done_cnt;
    start_job(1'b0, 128'h77, 128'h0, 16'd0);
    check("t4_done", 128'(done), 128'd1);
    check("t4_busy", 128'(busy), 128'd0);
    check("t4_enable", 128'(tree_enable), 128'd0);
    repeat (5) @(negedge clk);
    check("t4_nenable", 128'(en_cnt - eb), 128'd0);
    check("t4_nwords", 128'(word_cnt - wb), 128'd0);
    check("t4_ndone", 128'(done_cnt - db), 128'd1);

    // Start pulse mid-job is ignored
    wb = word_cnt; eb = en_cnt; db = done_cnt;
    start_job(1'b0, 128'h10, 128'h0, 16'd1);
    repeat (5) @(negedge clk);
    seed_in = 128'h999; num_batches = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_seed_held", tree_seed, 128'h10);
    wait_done("t5_done", 200);
    check("t5_nenable", 128'(en_cnt - eb), 128'd1);
    check("t5_seed", en_seed[eb], 128'h10);
    check("t5_nwords", 128'(word_cnt - wb), 128'd8);
    check("t5_lastword", word_data[wb+7], 128'hA7);
    check("t5_ndone", 128'(done_cnt - db), 128'd1);
    repeat (3) @(negedge clk);
    check("t5_idle", 128'(busy), 128'd0);

    // Timeout on the 16-cycle instance
    num_batches = 16'd1; seed_in = 128'h5; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_enable", 128'(tree_enable2), 128'd1);
    n = 0;
    while (error2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_err_cycles", 128'(n), 128'd17);
    @(negedge clk);
    check("t6_busy", 128'(busy2), 128'd0);
    check("t6_error_sticky", 128'(error2), 128'd1);
    check("t6_valid", 128'(out_valid2), 128'd0);
    check("t6_ndone", 128'(done2_cnt), 128'd0);
    num_batches = 16'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_error_clear", 128'(error2), 128'd0);

    // Reset during PRESENT of word 4
    wb = word_cnt; eb = en_cnt; db = done_cnt;
    start_job(1'b1, 128'h10, 128'h66, 16'd1);
    wait_word(128'hA4, 300);
    check("t7_reach_w4", out_data, 128'hA4);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t7_busy",   128'(busy), 128'd0);
    check("t7_done",   128'(done), 128'd0);
    check("t7_valid",  128'(out_valid), 128'd0);
    check("t7_data",   out_data, 128'd0);
    check("t7_last",   128'(out_last), 128'd0);
    check("t7_enable", 128'(tree_enable), 128'd0);
    check("t7_func",   128'(tree_func), 128'd0);
    check("t7_seed",   tree_seed, 128'd0);
    check("t7_delta",  tree_delta, 128'd0);
    check("t7_index",  128'(tree_msg_index), 128'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (60) @(negedge clk);
    check("t7_ndone", 128'(done_cnt - db), 128'd0);
    check("t7_nwords", 128'(word_cnt - wb), 128'd4);
    check("t7_nenable", 128'(en_cnt - eb), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sender_tree_sched.md
Name: sender_tree_sched

Overview:
- Batch sequencer in front of the sender tree cluster (TREE_NUM trees sharing seed/delta, output selected by msg_index).
- For each batch it does three things:
  - launches the cluster with a per-batch seed;
  - waits for the cluster's aggregate done;
  - drains all TREE_NUM tree outputs in index order onto a valid/ready stream.
- Sits between the host/config layer and the cluster. Owns all cluster control inputs.

Parameters:
- TREE_NUM, 8: trees in the attached cluster; words drained per batch.
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles before error abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- func_in  in  1  cluster function select; latched at start.
- seed_in  in  128  base seed; latched at start.
- delta_in  in  128  correlation delta; latched at start.
- num_batches  in  16  batches per job; latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.
- error  out  1  sticky timeout flag.
- tree_enable  out  1  cluster enable.
- tree_func  out  1  cluster func.
- tree_seed  out  128  cluster seed.
- tree_delta  out  128  cluster delta.
- tree_msg_index  out  32  cluster output select.
- tree_done  in  1  cluster aggregate done.
- tree_out  in  128  cluster selected output (combinational from tree_msg_index).
- out_valid  out  1  stream valid.
- out_data  out  128  stream word.
- out_last  out  1  final word of job; qualified by out_valid.
- out_ready  in  1  stream ready.

Behaviour:
- Reset: all state and outputs registered.
  - Outputs go to 0 (busy, done, error, tree_enable, tree_func, tree_seed, tree_delta, tree_msg_index, out_valid, out_data, out_last).
  - State goes to IDLE.
  - rst mid-job aborts immediately. No done pulse. The stream word is dropped.
- States: IDLE, LAUNCH, WAIT, SEL, PRESENT, NEXT, FINISH, ERR.
- IDLE
  - start=1 and num_batches!=0:
    - latch func, seed, delta and num_batches;
    - clear batch counter and error;
    - go to LAUNCH.
  - start=1 and num_batches==0: clear error, pulse done next cycle, stay IDLE.
  - start while busy is ignored.
- LAUNCH
  - tree_enable=1 for exactly this one cycle.
  - tree_seed = seed_lat + batch, a 128-bit add that wraps mod 2^128.
  - tree_func and tree_delta come from the latched values and hold stable until the job ends.
  - Clear the timer, go to WAIT.
- WAIT
  - tree_done=1 goes to SEL with idx=0. tree_done is sampled from the first WAIT cycle onward.
  - Otherwise increment the timer. When timer==TIMEOUT_CYCLES-1, go to ERR.
- SEL
  - tree_msg_index=idx. Zero-extend idx to 32 bits.
  - Wait one cycle for the mux to settle, then go to PRESENT.
- PRESENT
  - On entry, out_data captures tree_out and out_valid goes to 1.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - On the out_valid & out_ready handshake, out_valid drops the next cycle unless a new word is presented:
    - if idx==TREE_NUM-1, go to NEXT;
    - otherwise idx++ and go to SEL.
  - Throughput is one word per 2 cycles at most.
- out_last=1 only with the word where idx==TREE_NUM-1 and batch==num_batches-1.
- NEXT
  - If batch==num_batches-1, go to FINISH.
  - Otherwise batch++ and go to LAUNCH.
- FINISH: done=1 for one cycle, then IDLE.
- ERR
  - error=1 (sticky until the next accepted start or rst).
  - out_valid=0, tree_enable=0.
  - Go to IDLE. No done pulse.
- Words per job = num_batches*TREE_NUM, emitted in order of batch, then idx.
- Start-to-first-tree_enable latency: 1 cycle (start sampled in cycle 0, tree_enable high in cycle 1).

Test Plan:
- Single batch:
  - Stimulus: TREE_NUM=8, num_batches=1, seed_in=0x10, model tree_done 20 cycles after enable, tree_out=0xA0+msg_index, out_ready=1.
  - Response: tree_enable pulses once with tree_seed=0x10; 8 words 0xA0..0xA7 in order; out_last only on 0xA7; done pulses 1 cycle after the last handshake.
- Backpressure:
  - Stimulus: same as single batch, with out_ready low for 5 cycles on word 3.
  - Response: out_data=0xA3 held stable with out_valid=1 throughout; no word loss or duplication.
- Multi-batch seed wrap:
  - Stimulus: num_batches=3, seed_in=2^128-2.
  - Response: tree_seed per LAUNCH = 2^128-2, 2^128-1, 0; 24 words total; exactly one out_last.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, tree_done never rises.
  - Response: error=1 after 16 WAIT cycles; return to IDLE; busy=0; no done; a subsequent start clears error.
- Zero batches and ignored start:
  - Stimulus: num_batches=0 start; later a start pulse mid-job.
  - Response: first gives a done pulse with no tree_enable and no words; the mid-job start has no effect on sequence or latched seed.
- Reset mid-drain:
  - Stimulus: rst asserted during PRESENT of word 4.
  - Response: next cycle all outputs 0, state IDLE; no done.
